// File: rtl/stream_upsizer.sv
// Packs RATIO narrow beats into one wide word with a registered valid/ready output.
// A packet-end flag flushes a partial word with unused lanes zeroed and masked via keep.
module stream_upsizer #(
  parameter int unsigned IN_WIDTH = 32,
  parameter int unsigned RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [IN_WIDTH-1:0]       in_data_i,
  input  logic                      in_last_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [IN_WIDTH*RATIO-1:0] out_data_o,
  output logic [RATIO-1:0]          out_keep_o,
  output logic                      out_last_o
);

  localparam int unsigned OutW = IN_WIDTH * RATIO;
  localparam int unsigned CntW = $clog2(RATIO);
  localparam logic [CntW-1:0] CntMax = CntW'(RATIO - 1);

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [OutW-1:0]  acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [OutW-1:0]  out_data_q, out_data_d;
  logic [RATIO-1:0] out_keep_q, out_keep_d;
  logic             out_last_q, out_last_d;

  logic             accept;
  logic             complete;
  logic [OutW-1:0]  merged;
  logic [RATIO-1:0] keep_new;

  // Depends only on output state and out_ready_i, so no in_* to out_* path.
  assign in_ready_o = !out_valid_q || out_ready_i;

  always_comb begin
    accept   = in_valid_i && in_ready_o;
    complete = accept && ((cnt_q == CntMax) || in_last_i);

    // Lanes above cnt_q are still zero because the accumulator clears per word.
    merged = acc_q;
    merged[cnt_q*IN_WIDTH +: IN_WIDTH] = in_data_i;

    keep_new = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      keep_new[k] = (CntW'(k) <= cnt_q);
    end

    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;

    if (accept) begin
      if (complete) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
        acc_d = merged;
      end
    end

    if (complete) begin
      out_valid_d = 1'b1;
      out_data_d  = merged;
      out_keep_d  = keep_new;
      out_last_d  = in_last_i;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_keep_o  = out_keep_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_stream_upsizer.sv
// Directed bench for stream_upsizer (IN_WIDTH=32, RATIO=4); inputs change and outputs are
// checked 1 time unit after each rising edge.
module tb_stream_upsizer;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_keep;
  logic         out_last;

  int vectors;
  int miscompares;

  logic [127:0] exp_acc;
  logic [127:0] held_data;
  logic [31:0]  d;

  stream_upsizer #(
    .IN_WIDTH(32),
    .RATIO   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_keep_o (out_keep),
    .out_last_o (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] data, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    in_last  = 1'b1;
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    out_ready   = 1'b1;

    // Reset values.
    #2;
    chk("rst_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_data",  out_data,        128'h0);
    chk("rst_keep",  128'(out_keep),  128'(4'b0000));
    chk("rst_last",  128'(out_last),  128'(1'b0));
    out_ready = 1'b0;
    #1;
    chk("rst_ready", 128'(in_ready),  128'(1'b1));
    out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Full four-beat packet.
    beat(32'h1111_1111, 1'b0);
    beat(32'h2222_2222, 1'b0);
    beat(32'h3333_3333, 1'b0);
    chk("full_pre_valid", 128'(out_valid), 128'(1'b0));
    beat(32'h4444_4444, 1'b1);
    in_valid = 1'b0;
    chk("full_valid", 128'(out_valid), 128'(1'b1));
    chk("full_data",  out_data,        128'h44444444_33333333_22222222_11111111);
    chk("full_keep",  128'(out_keep),  128'(4'b1111));
    chk("full_last",  128'(out_last),  128'(1'b1));
    idle();
    chk("full_one_cycle", 128'(out_valid), 128'(1'b0));

    // Partial flush.
    beat(32'hAAAA_AAAA, 1'b0);
    beat(32'hBBBB_BBBB, 1'b1);
    in_valid = 1'b0;
    chk("part_valid", 128'(out_valid), 128'(1'b1));
    chk("part_data",  out_data,        128'h00000000_00000000_BBBBBBBB_AAAAAAAA);
    chk("part_keep",  128'(out_keep),  128'(4'b0011));
    chk("part_last",  128'(out_last),  128'(1'b1));
    idle();
    chk("part_drop", 128'(out_valid), 128'(1'b0));

    // Continuous 12-beat stream.
    exp_acc = '0;
    for (int i = 0; i < 12; i++) begin
      d = 32'hC0DE_0000 | 32'(i);
      chk($sformatf("str_ready%0d", i), 128'(in_ready), 128'(1'b1));
      exp_acc[(i % 4)*32 +: 32] = d;
      beat(d, i == 11);
      chk($sformatf("str_valid%0d", i), 128'(out_valid), 128'(i % 4 == 3));
      if (i % 4 == 3) begin
        chk($sformatf("str_data%0d", i), out_data, exp_acc);
        chk($sformatf("str_last%0d", i), 128'(out_last), 128'(i == 11));
        exp_acc = '0;
      end
    end
    idle();

    // Back-pressure after a word completes.
    beat(32'hC000_0000, 1'b0);
    beat(32'hC000_0001, 1'b0);
    beat(32'hC000_0002, 1'b0);
    beat(32'hC000_0003, 1'b0);
    held_data = 128'hC0000003_C0000002_C0000001_C0000000;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hBAD0_0000 | 32'(i);
      in_last  = 1'b1;
      #1;
      chk($sformatf("bp_ready%0d", i), 128'(in_ready),  128'(1'b0));
      chk($sformatf("bp_valid%0d", i), 128'(out_valid), 128'(1'b1));
      chk($sformatf("bp_data%0d", i),  out_data,        held_data);
      chk($sformatf("bp_keep%0d", i),  128'(out_keep),  128'(4'b1111));
      chk($sformatf("bp_last%0d", i),  128'(out_last),  128'(1'b0));
      step();
    end
    out_ready = 1'b1;
    in_data   = 32'hD000_0000;
    in_last   = 1'b0;
    #1;
    chk("bp_release_ready", 128'(in_ready), 128'(1'b1));
    step();
    chk("bp_emit_valid", 128'(out_valid), 128'(1'b0));
    beat(32'hD000_0001, 1'b0);
    beat(32'hD000_0002, 1'b0);
    beat(32'hD000_0003, 1'b1);
    in_valid = 1'b0;
    chk("bp_next_valid", 128'(out_valid), 128'(1'b1));
    chk("bp_next_data",  out_data,        128'hD0000003_D0000002_D0000001_D0000000);
    chk("bp_next_last",  128'(out_last),  128'(1'b1));
    idle();

    // Single-beat packets back to back: emit and reload in one cycle.
    beat(32'h5A5A_5A5A, 1'b1);
    chk("single_valid", 128'(out_valid), 128'(1'b1));
    chk("single_data",  out_data,        128'h00000000_00000000_00000000_5A5A5A5A);
    chk("single_keep",  128'(out_keep),  128'(4'b0001));
    chk("single_last",  128'(out_last),  128'(1'b1));
    beat(32'h0000_00A5, 1'b1);
    in_valid = 1'b0;
    chk("b2b_valid", 128'(out_valid), 128'(1'b1));
    chk("b2b_data",  out_data,        128'h00000000_00000000_00000000_000000A5);
    idle();
    chk("b2b_drop", 128'(out_valid), 128'(1'b0));

    // Reset mid-word discards the partial accumulator.
    beat(32'hF000_0001, 1'b0);
    beat(32'hF000_0002, 1'b0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("mrst_valid", 128'(out_valid), 128'(1'b0));
    chk("mrst_data",  out_data,        128'h0);
    chk("mrst_keep",  128'(out_keep),  128'(4'b0000));
    chk("mrst_last",  128'(out_last),  128'(1'b0));
    chk("mrst_ready", 128'(in_ready),  128'(1'b1));
    step();
    rst_n = 1'b1;
    step();
    beat(32'h6000_0000, 1'b0);
    beat(32'h6000_0001, 1'b0);
    beat(32'h6000_0002, 1'b0);
    chk("mrst_no_early", 128'(out_valid), 128'(1'b0));
    beat(32'h6000_0003, 1'b0);
    in_valid = 1'b0;
    chk("mrst_word_valid", 128'(out_valid), 128'(1'b1));
    chk("mrst_word_data",  out_data,        128'h60000003_60000002_60000001_60000000);
    chk("mrst_word_keep",  128'(out_keep),  128'(4'b1111));
    chk("mrst_word_last",  128'(out_last),  128'(1'b0));
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
